// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared types and constants for the serial parity frame checker.
//   state_t   : deframer state (IDLE, DATA, PARITY)
//   PAR_EVEN  : odd_mode value selecting even parity
//   PAR_ODD   : odd_mode value selecting odd parity
//   exp_parity: expected parity bit for a given data XOR and mode
// -----------------------------------------------------------------------------
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Even parity: the parity bit equals the XOR of the data bits.
   // Odd parity: the parity bit is the inverse of that XOR.
   function automatic logic exp_parity(input logic data_xor, input logic mode);
      return data_xor ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with clear-then-increment semantics: when clr and inc
// are both high in the same cycle the result is 1 (clear first, then count).
// The count sticks at 2^W-1 and never wraps.
// Ports:
//   clk   in  1  clock
//   reset in  1  synchronous, active-high
//   clr   in  1  synchronous clear
//   inc   in  1  increment request
//   count out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] r_count;
   logic [W-1:0] w_base;
   logic [W-1:0] w_next;

   always_comb begin
      w_base = clr ? '0 : r_count;
      w_next = w_base;
      if (inc && (w_base != MAX)) begin
         w_next = w_base + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/parity_frame_checker.sv
// -----------------------------------------------------------------------------
// parity_frame_checker
// Deframes a serial stream (start strobe, DATA_BITS data bits LSB-first, one
// parity bit), checks even/odd parity selected per frame, presents the word
// with an error flag and keeps a saturating parity-error count.
// Ports:
//   clk          in  1          clock
//   reset        in  1          synchronous, active-high
//   frame_start  in  1          strobe beginning a new frame (no data bit)
//   bit_valid    in  1          qualifies serial_in
//   serial_in    in  1          serial data or parity bit
//   odd_mode     in  1          0 even / 1 odd, sampled on frame_start
//   clear_count  in  1          synchronous clear of err_count
//   frame_valid  out 1          one-cycle pulse, frame complete
//   data_out     out DATA_BITS  assembled word, held until next frame_valid
//   parity_err   out 1          error flag of last completed frame
//   running_odd  out 1          XOR of bits accepted in current frame
//   err_count    out ERR_CNT_W  saturating count of erroneous frames
// -----------------------------------------------------------------------------
module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic                 bit_valid,
   input  logic                 serial_in,
   input  logic                 odd_mode,
   input  logic                 clear_count,
   output logic                 frame_valid,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 running_odd,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept_data;
   logic                 w_accept_par;
   logic                 w_par_err;

   logic [CNT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_word;
   logic [DATA_BITS-1:0] w_word_nxt;
   logic                 r_mode;
   logic                 r_running;
   logic                 r_frame_valid;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_parity_err;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and bit-acceptance strobes.
   // frame_start wins over bit_valid in every state, so a colliding bit is
   // dropped and any frame in progress is abandoned silently.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_accept_data = 1'b0;
      w_accept_par  = 1'b0;
      if (frame_start) begin
         w_state_nxt = DATA;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            DATA: begin
               if (bit_valid) begin
                  w_accept_data = 1'b1;
                  if (r_bit_cnt == LAST_IDX) begin
                     w_state_nxt = PARITY;
                  end
               end
            end
            PARITY: begin
               if (bit_valid) begin
                  w_accept_par = 1'b1;
                  w_state_nxt  = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Place serial_in at the position given by the bit counter (LSB first).
   always_comb begin
      w_word_nxt = r_word;
      for (int i = 0; i < DATA_BITS; i++) begin
         if (r_bit_cnt == CNT_W'(i)) begin
            w_word_nxt[i] = serial_in;
         end
      end
   end

   // In PARITY, r_running holds exactly the XOR of the data bits, so it
   // doubles as the data parity without a separate reduction over r_word.
   assign w_par_err = (serial_in != exp_parity(r_running, r_mode));

   // ---------------------------------------------------------------------------
   // Deframing datapath and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_cnt     <= '0;
         r_word        <= '0;
         r_mode        <= PAR_EVEN;
         r_running     <= 1'b0;
         r_frame_valid <= 1'b0;
         r_data_out    <= '0;
         r_parity_err  <= 1'b0;
      end else begin
         r_frame_valid <= w_accept_par;
         if (frame_start) begin
            r_bit_cnt <= '0;
            r_running <= 1'b0;
            r_mode    <= odd_mode;
         end else if (w_accept_data) begin
            r_word    <= w_word_nxt;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_running <= r_running ^ serial_in;
         end else if (w_accept_par) begin
            r_data_out   <= r_word;
            r_parity_err <= w_par_err;
            r_running    <= r_running ^ serial_in;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Error counter: counts on the same edge that completes the frame
   // ---------------------------------------------------------------------------
   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_count),
      .inc   (w_accept_par && w_par_err),
      .count (err_count)
   );

   assign frame_valid = r_frame_valid;
   assign data_out    = r_data_out;
   assign parity_err  = r_parity_err;
   assign running_odd = r_running;

endmodule

// File: tb/tb_parity_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_checker
// Directed bench for parity_frame_checker (DATA_BITS=8, ERR_CNT_W=2).
// Expected frame results are pushed when the parity bit is driven and popped
// by a monitor whenever frame_valid is seen.
// -----------------------------------------------------------------------------
module tb_parity_frame_checker;

   localparam int DB = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic          bit_valid;
   logic          serial_in;
   logic          odd_mode;
   logic          clear_count;
   logic          frame_valid;
   logic [DB-1:0] data_out;
   logic          parity_err;
   logic          running_odd;
   logic [CW-1:0] err_count;

   typedef struct packed {
      logic [DB-1:0] d;
      logic          perr;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad   = 0;
   int            fv_cnt = 0;
   logic [CW-1:0] exp_cnt = '0;

   parity_frame_checker #(
      .DATA_BITS (DB),
      .ERR_CNT_W (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .serial_in   (serial_in),
      .odd_mode    (odd_mode),
      .clear_count (clear_count),
      .frame_valid (frame_valid),
      .data_out    (data_out),
      .parity_err  (parity_err),
      .running_odd (running_odd),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         exp_t e;
         fv_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_frame_valid", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("data_out",   32'(data_out),   32'(e.d));
            chk("parity_err", 32'(parity_err), 32'(e.perr));
            chk("err_count",  32'(err_count),  32'(e.cnt));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic odd);
      frame_start = 1'b1;
      odd_mode    = odd;
      tick();
      frame_start = 1'b0;
      odd_mode    = ~odd;   // must be ignored until the next frame_start
   endtask

   task automatic send_bit(input logic b, input logic gap);
      if (gap) begin
         bit_valid = 1'b0;
         tick();
      end
      bit_valid = 1'b1;
      serial_in = b;
      tick();
      bit_valid = 1'b0;
   endtask

   // Data bits then parity; pushes the expectation and checks the pulse.
   task automatic finish_frame(input logic [DB-1:0] d, input logic odd, input logic par,
                               input logic gap, input logic clr);
      logic perr;
      exp_t e;
      int   fv0;
      for (int i = 0; i < DB; i++) send_bit(d[i], gap);
      perr = (par != ((^d) ^ odd));
      if (clr) exp_cnt = '0;
      if (perr && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
      e.d = d; e.perr = perr; e.cnt = exp_cnt;
      q.push_back(e);
      fv0 = fv_cnt;
      if (gap) begin
         bit_valid = 1'b0;
         tick();
      end
      chk("fv_before_parity", 32'(frame_valid), 32'd0);
      bit_valid   = 1'b1;
      serial_in   = par;
      clear_count = clr;
      tick();
      bit_valid   = 1'b0;
      clear_count = 1'b0;
      chk("fv_pulse",    32'(frame_valid), 32'd1);
      chk("running_odd", 32'(running_odd), 32'((^d) ^ par));
      tick();
      chk("fv_one_cycle", 32'(frame_valid), 32'd0);
      chk("fv_count",     32'(fv_cnt),      32'(fv0 + 1));
   endtask

   task automatic frame(input logic [DB-1:0] d, input logic odd, input logic par,
                        input logic gap, input logic clr);
      start_frame(odd);
      finish_frame(d, odd, par, gap, clr);
   endtask

   task automatic check_cnt(input string tag);
      chk(tag, 32'(err_count), 32'(exp_cnt));
   endtask

   initial begin
      int fv0;
      reset = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
      odd_mode = 1'b0; clear_count = 1'b0;
      tick(); tick();
      chk("rst_frame_valid", 32'(frame_valid), 32'd0);
      chk("rst_data_out",    32'(data_out),    32'd0);
      chk("rst_parity_err",  32'(parity_err),  32'd0);
      chk("rst_running_odd", 32'(running_odd), 32'd0);
      chk("rst_err_count",   32'(err_count),   32'd0);
      reset = 1'b0;
      tick();

      // bits in IDLE are ignored
      fv0 = fv_cnt;
      for (int i = 0; i < DB + 1; i++) send_bit(1'b1, 1'b0);
      chk("idle_ignores_bits", 32'(fv_cnt), 32'(fv0));
      chk("idle_running_odd",  32'(running_odd), 32'd0);

      // 1. even, good
      frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      check_cnt("s1_err_count");
      // 2. odd, bad
      frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      check_cnt("s2_err_count");
      // odd, good: running_odd ends at 1
      frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("odd_good_running", 32'(running_odd), 32'd1);
      // 3. gapped copy of scenario 1
      frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
      check_cnt("s3_err_count");

      // 4. abort after 5 bits, restart colliding with a valid bit
      fv0 = fv_cnt;
      start_frame(1'b1);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      frame_start = 1'b1; odd_mode = 1'b0;
      bit_valid = 1'b1; serial_in = 1'b1;   // dropped
      tick();
      frame_start = 1'b0; bit_valid = 1'b0; odd_mode = 1'b1;
      chk("abort_running_clr", 32'(running_odd), 32'd0);
      finish_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort_single_fv", 32'(fv_cnt), 32'(fv0 + 1));

      // 5. saturation with 2-bit counter
      clear_count = 1'b1; exp_cnt = '0;
      tick();
      clear_count = 1'b0;
      check_cnt("s5_clear_first");
      for (int k = 0; k < 5; k++) begin
         frame(8'(8'h11 * k + 8'h5A), 1'b0, ~(^(8'(8'h11 * k + 8'h5A))), 1'b0, 1'b0);
         check_cnt("s5_sat_step");
      end
      chk("s5_saturated", 32'(err_count), 32'd3);
      frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("s5_clear_and_inc", 32'(err_count), 32'd1);
      clear_count = 1'b1; exp_cnt = '0;
      tick();
      clear_count = 1'b0;
      chk("s5_clear_alone", 32'(err_count), 32'd0);

      // 6. reset mid-frame with non-zero outputs beforehand
      frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      start_frame(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cnt = '0;
      chk("mid_rst_frame_valid", 32'(frame_valid), 32'd0);
      chk("mid_rst_data_out",    32'(data_out),    32'd0);
      chk("mid_rst_parity_err",  32'(parity_err),  32'd0);
      chk("mid_rst_running_odd", 32'(running_odd), 32'd0);
      chk("mid_rst_err_count",   32'(err_count),   32'd0);
      fv0 = fv_cnt;
      for (int i = 0; i < DB + 2; i++) send_bit(1'b1, 1'b0);
      tick();
      chk("post_rst_no_fv", 32'(fv_cnt), 32'(fv0));
      chk("post_rst_running", 32'(running_odd), 32'd0);

      // recovery after reset
      frame(8'h5B, 1'b1, 1'b0, 1'b0, 1'b0);
      check_cnt("recover_err_count");

      tick();
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

- Parametrised serial parity checker; successor to the single-bit PAR/IMPAR detector.
- Deframes a serial stream: a start strobe, then `DATA_BITS` data bits LSB-first, then one parity bit.
- Checks even or odd parity, selectable per frame, and presents the assembled word with an error flag.
- Keeps a saturating parity-error count; sits between a serial line sampler and the word-level consumer.

## Interface

Parameters:
- `DATA_BITS`, 8 — data bits per frame, excluding the parity bit; legal range ≥ 1.
- `ERR_CNT_W`, 8 — width of the saturating error counter; legal range ≥ 1.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — synchronous, active-high.
- `frame_start` in 1 — one-cycle strobe that begins a new frame; carries no data bit.
- `bit_valid` in 1 — qualifies `serial_in`.
- `serial_in` in 1 — serial data or parity bit.
- `odd_mode` in 1 — 0 = even parity, 1 = odd parity; sampled only on `frame_start`.
- `clear_count` in 1 — synchronous clear of `err_count`.
- `frame_valid` out 1 — one-cycle pulse: frame complete.
- `data_out` out `DATA_BITS` — assembled word; holds until the next `frame_valid`.
- `parity_err` out 1 — error flag for the last completed frame; holds with `data_out`.
- `running_odd` out 1 — XOR of all bits accepted so far in the current frame, parity bit included.
- `err_count` out `ERR_CNT_W` — number of frames completed with a parity error, saturating.

## Operation

- States: IDLE, DATA, PARITY.
- `frame_start` in any state:
  - go to DATA;
  - clear the bit counter and `running_odd`;
  - latch `odd_mode`;
  - abort any frame in progress without asserting `frame_valid`.
- `frame_start` has priority over `bit_valid` in the same cycle; that bit is dropped.
- IDLE: `bit_valid` is ignored.
- DATA:
  - each `bit_valid` shifts `serial_in` into the word at index = bit counter (LSB first);
  - each accepted bit XORs into `running_odd` and increments the counter;
  - on the `DATA_BITS`-th accepted bit, go to PARITY.
- PARITY: on `bit_valid`:
  - expected parity bit = data XOR, inverted when the latched mode is odd;
  - `parity_err` = (`serial_in` != expected);
  - `data_out` ← assembled word;
  - `frame_valid` pulses;
  - `running_odd` XORs in the parity bit;
  - go to IDLE.
- Invariant: `running_odd` = 0 after a good even-mode frame and = 1 after a good odd-mode frame.
- `err_count`:
  - increments by 1 on each completed frame with `parity_err` = 1;
  - saturates at 2^`ERR_CNT_W` − 1; no wrap.
  - `clear_count` alone sets it to 0.
  - `clear_count` together with a completing erroneous frame sets it to 1; clear applies first, then the frame counts.
- Reset values: state IDLE; every output 0; internal word, bit counter and latched mode 0.

## Timing

- All outputs are registered.
- `frame_valid`, `data_out`, `parity_err` and `err_count` update on the clock edge that accepts the parity bit, so they are visible in the following cycle.
- `frame_valid` is high for exactly one cycle.
- Minimum frame: `frame_start` at cycle 0, bits at cycles 1..`DATA_BITS`+1, `frame_valid` high in cycle `DATA_BITS`+2.
- Gaps in `bit_valid` stretch a frame arbitrarily; there is no timeout.
- `running_odd` updates one cycle after each accepted bit.
- `reset` mid-frame: next cycle is IDLE with all outputs 0; bits before the next `frame_start` are ignored.

## Structure

- Package `parity_pkg`:
  - `state_t` enum {IDLE, DATA, PARITY};
  - mode constants `PAR_EVEN` = 0, `PAR_ODD` = 1.
- Sub-module `sat_counter` (parameter `W`; ports clk, reset, clr, inc, count): saturating counter with clear-then-increment semantics; instantiated for `err_count`.
- The bit counter is sized `$clog2(DATA_BITS+1)`.

## Test plan

All scenarios use `DATA_BITS`=8.

1. **Even, good frame.** `odd_mode`=0, 0xA5 LSB-first, parity 0 → `frame_valid` 1 cycle, `data_out`=0xA5, `parity_err`=0, `err_count`=0, `running_odd`=0.
2. **Odd, bad frame.** `odd_mode`=1, 0xA5, parity 0 → `parity_err`=1, `err_count`=1, `running_odd`=0.
3. **Gapped input.** Scenario 1 with `bit_valid` low every other cycle → identical outputs; `frame_valid` 9 cycles later than in scenario 1.
4. **Abort.** `frame_start`, 5 bits, `frame_start`, then 0x01 with parity 1 (even) → exactly one `frame_valid`, `data_out`=0x01, `parity_err`=0; also a `frame_start` colliding with `bit_valid` drops that bit.
5. **Saturation.** `ERR_CNT_W`=2, five erroneous frames → `err_count`=3; `clear_count` coincident with a sixth erroneous frame → 1; `clear_count` alone → 0.
6. **Reset mid-frame.** `reset` after 4 bits → all outputs 0; bits sent without `frame_start` produce no `frame_valid`.
